srt_radix2_core: RTL and testbench

//  Sequential radix-2 SRT mantissa divider. It sits directly downstream of the operand normalizer.
//  It consumes the 25-bit {2'b0x, frac} mantissas, the exponent and the sign that the normalizer produces.
//  It pre-shifts subnormal operands, runs one quotient digit {-1,0,+1} per cycle with on-the-fly

---
 rtl/srt_radix2_core.sv | 155 +++++++++++++++
 tb/tb_srt_radix2_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/srt_radix2_core.sv
// Sequential radix-2 SRT mantissa divider: prenormalizes subnormal operands, retires one
// {-1,0,+1} digit per cycle with on-the-fly conversion, then corrects by the remainder sign.
module srt_radix2_core #(
  parameter int MAN_W = 25,
  parameter int Q_W   = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [MAN_W-1:0] x_man,
  input  logic [MAN_W-1:0] d_man,
  input  logic [7:0]       exp_in,
  input  logic             sign_in,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   q_man,
  output logic             sticky,
  output logic [7:0]       exp_out,
  output logic             sign_out,
  output logic [4:0]       x_lz,
  output logic [4:0]       d_lz,
  output logic             div_by_zero,
  output logic             zero_result
);

  // Residual: 4 integer bits (incl. sign) and MAN_W-1 fraction bits.
  localparam int W_W   = MAN_W + 3;
  localparam int F_W   = W_W - 4;
  localparam int CNT_W = $clog2(Q_W);
  localparam int HB    = MAN_W - 2;

  typedef enum logic [1:0] {IDLE, PRENORM, ITER, FIX} state_t;

  state_t                state, next_state;
  logic [MAN_W-1:0]      x_sh, d_sh;
  logic signed [W_W-1:0] w, dw;
  logic [Q_W-1:0]        q_reg, qm_reg;
  logic [CNT_W-1:0]      cnt;

  logic signed [W_W-1:0] two_w, w_next, rem;
  logic signed [4:0]     est;
  logic                  q_pos, q_neg, special;

  assign special = (x_man == '0) || (d_man == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = special ? FIX : PRENORM;
      PRENORM: if (x_sh[HB] && d_sh[HB]) next_state = ITER;
      ITER:    if (cnt == '0) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Digit selection looks only at the integer bits plus one fraction bit of 2w.
  always_comb begin
    two_w  = w <<< 1;
    est    = two_w[W_W-1:F_W-1];
    q_pos  = (est >= 5'sd2);
    q_neg  = (est <= -5'sd3);
    w_next = two_w;
    if (q_pos)      w_next = two_w - dw;
    else if (q_neg) w_next = two_w + dw;
    rem = w[W_W-1] ? (w + dw) : w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_sh        <= '0;
      d_sh        <= '0;
      w           <= '0;
      dw          <= '0;
      q_reg       <= '0;
      qm_reg      <= '0;
      cnt         <= '0;
      done        <= 1'b0;
      q_man       <= '0;
      sticky      <= 1'b0;
      exp_out     <= '0;
      sign_out    <= 1'b0;
      x_lz        <= '0;
      d_lz        <= '0;
      div_by_zero <= 1'b0;
      zero_result <= 1'b0;
    end else begin
      done <= (state == FIX);
      case (state)
        IDLE: if (start) begin
          x_sh        <= x_man;
          d_sh        <= d_man;
          exp_out     <= exp_in;
          sign_out    <= sign_in;
          x_lz        <= '0;
          d_lz        <= '0;
          q_man       <= '0;
          sticky      <= 1'b0;
          div_by_zero <= (d_man == '0);
          zero_result <= (x_man == '0) && (d_man != '0);
          w           <= '0;
          dw          <= '0;
          q_reg       <= '0;
          qm_reg      <= '0;
        end
        PRENORM: begin
          if (x_sh[HB] && d_sh[HB]) begin
            w   <= {{(W_W-MAN_W){1'b0}}, x_sh};
            dw  <= {{(W_W-MAN_W-1){1'b0}}, d_sh, 1'b0};
            cnt <= CNT_W'(Q_W - 1);
          end else begin
            if (!x_sh[HB]) begin
              x_sh <= x_sh << 1;
              x_lz <= x_lz + 5'd1;
            end
            if (!d_sh[HB]) begin
              d_sh <= d_sh << 1;
              d_lz <= d_lz + 5'd1;
            end
          end
        end
        ITER: begin
          w   <= w_next;
          cnt <= cnt - 1'b1;
          // QM tracks Q-1 so a -1 digit never needs a borrow chain.
          if (q_pos) begin
            q_reg  <= {q_reg[Q_W-2:0], 1'b1};
            qm_reg <= {q_reg[Q_W-2:0], 1'b0};
          end else if (q_neg) begin
            q_reg  <= {qm_reg[Q_W-2:0], 1'b1};
            qm_reg <= {qm_reg[Q_W-2:0], 1'b0};
          end else begin
            q_reg  <= {q_reg[Q_W-2:0], 1'b0};
            qm_reg <= {qm_reg[Q_W-2:0], 1'b1};
          end
        end
        FIX: begin
          q_man  <= w[W_W-1] ? qm_reg : q_reg;
          sticky <= (rem != '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srt_radix2_core.sv
// Directed-vector bench for srt_radix2_core: quotient, sticky, flags, lz counts and latency.
module tb_srt_radix2_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [24:0] x_man = '0;
  logic [24:0] d_man = '0;
  logic [7:0]  exp_in = '0;
  logic        sign_in = 1'b0;
  logic        busy, done, sticky, sign_out, div_by_zero, zero_result;
  logic [26:0] q_man;
  logic [7:0]  exp_out;
  logic [4:0]  x_lz, d_lz;

  int n_checks = 0;
  int n_pass   = 0;
  int inv_viol = 0;

  srt_radix2_core dut (
    .clk(clk), .rst(rst), .start(start), .x_man(x_man), .d_man(d_man),
    .exp_in(exp_in), .sign_in(sign_in), .busy(busy), .done(done), .q_man(q_man),
    .sticky(sticky), .exp_out(exp_out), .sign_out(sign_out), .x_lz(x_lz), .d_lz(d_lz),
    .div_by_zero(div_by_zero), .zero_result(zero_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] x;
    logic [24:0] d;
    logic [7:0]  e;
    logic        s;
    logic [26:0] q;
    logic        st;
    logic        dbz;
    logic        zr;
    logic [4:0]  xl;
    logic [4:0]  dl;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  // Residual bound |w| <= d, checked whenever a divisor is loaded.
  always @(negedge clk) begin
    logic signed [27:0] wv, dv, aw;
    wv = dut.w;
    dv = dut.dw;
    aw = wv[27] ? -wv : wv;
    if (!rst && dv != 0 && aw > dv) inv_viol++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic launch(input logic [24:0] x, input logic [24:0] d, input logic [7:0] e,
                        input logic s);
    @(negedge clk);
    x_man = x; d_man = d; exp_in = e; sign_in = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int edges, output bit busy_ok);
    edges   = base;
    busy_ok = 1'b1;
    while (edges < 200) begin
      @(posedge clk);
      #1 edges++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int edges;
    bit busy_ok;
    launch(v.x, v.d, v.e, v.s);
    chk({tag, "_busy_after_start"}, {31'b0, busy}, 32'd1);
    wait_done(0, edges, busy_ok);
    chk({tag, "_latency"}, edges, v.lat);
    chk({tag, "_busy_held"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, "_q_man"}, {5'b0, q_man}, {5'b0, v.q});
    chk({tag, "_sticky"}, {31'b0, sticky}, {31'b0, v.st});
    chk({tag, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, v.dbz});
    chk({tag, "_zero_result"}, {31'b0, zero_result}, {31'b0, v.zr});
    chk({tag, "_x_lz"}, {27'b0, x_lz}, {27'b0, v.xl});
    chk({tag, "_d_lz"}, {27'b0, d_lz}, {27'b0, v.dl});
    chk({tag, "_exp_out"}, {24'b0, exp_out}, {24'b0, v.e});
    chk({tag, "_sign_out"}, {31'b0, sign_out}, {31'b0, v.s});
  endtask

  initial begin
    int edges;
    bit busy_ok;

    //          x            d            exp    s     q            st    dbz   zr    xl     dl     lat
    vecs[0]  = '{25'h0800000, 25'h0800000, 8'h7f, 1'b0, 27'h4000000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 29};
    vecs[1]  = '{25'h0C00000, 25'h0800000, 8'h80, 1'b1, 27'h6000000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 29};
    vecs[2]  = '{25'h0800000, 25'h0C00000, 8'h01, 1'b0, 27'h2AAAAAA, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 29};
    vecs[3]  = '{25'h0800000, 25'h0000000, 8'h55, 1'b1, 27'h0,       1'b0, 1'b1, 1'b0, 5'd0,  5'd0, 1};
    vecs[4]  = '{25'h0000000, 25'h0800000, 8'haa, 1'b0, 27'h0,       1'b0, 1'b0, 1'b1, 5'd0,  5'd0, 1};
    vecs[5]  = '{25'h0000001, 25'h0800000, 8'h10, 1'b0, 27'h4000000, 1'b0, 1'b0, 1'b0, 5'd23, 5'd0, 52};
    vecs[6]  = '{25'h0000000, 25'h0000000, 8'hff, 1'b1, 27'h0,       1'b0, 1'b1, 1'b0, 5'd0,  5'd0, 1};
    vecs[7]  = '{25'h0E00000, 25'h0A00000, 8'h3c, 1'b1, 27'h5999999, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 29};
    vecs[8]  = '{25'h0800000, 25'h0400000, 8'h02, 1'b0, 27'h4000000, 1'b0, 1'b0, 1'b0, 5'd0,  5'd1, 30};
    vecs[9]  = '{25'h0FFFFFF, 25'h0800000, 8'h90, 1'b0, 27'h7FFFFF8, 1'b0, 1'b0, 1'b0, 5'd0,  5'd0, 29};
    vecs[10] = '{25'h0800000, 25'h0FFFFFF, 8'h91, 1'b1, 27'h2000002, 1'b1, 1'b0, 1'b0, 5'd0,  5'd0, 29};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_q_man", {5'b0, q_man}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Asynchronous reset in the middle of an iteration.
    launch(25'h0800000, 25'h0C00000, 8'h7e, 1'b1);
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    chk("midrst_exp_out", {24'b0, exp_out}, 32'd0);
    chk("midrst_sign_out", {31'b0, sign_out}, 32'd0);
    chk("midrst_q_man", {5'b0, q_man}, 32'd0);
    chk("midrst_state", {30'b0, dut.state}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // Table, back to back: every start after the first lands on the done cycle.
    for (int i = 0; i < 11; i++) begin
      if (i > 0) begin
        @(negedge clk);
        chk($sformatf("v%0d_start_on_done", i), {31'b0, done}, 32'd1);
      end
      run(vecs[i], $sformatf("v%0d", i));
    end

    // A start raised while busy must not disturb the running division.
    launch(25'h0C00000, 25'h0800000, 8'h44, 1'b0);
    edges = 0;
    repeat (4) begin
      @(posedge clk);
      #1 edges++;
    end
    @(negedge clk);
    x_man = 25'h0800000; d_man = 25'h0C00000; exp_in = 8'h99; sign_in = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 edges++;
    start = 1'b0;
    wait_done(edges, edges, busy_ok);
    chk("ign_latency", edges, 32'd29);
    chk("ign_q_man", {5'b0, q_man}, {5'b0, 27'h6000000});
    chk("ign_exp_out", {24'b0, exp_out}, 32'h44);
    chk("ign_sign_out", {31'b0, sign_out}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_idle_after", {31'b0, busy}, 32'd0);
    chk("hold_q_man", {5'b0, q_man}, {5'b0, 27'h6000000});
    chk("done_one_pulse", {31'b0, done}, 32'd0);

    // New start clears results immediately.
    launch(25'h0800000, 25'h0C00000, 8'h01, 1'b0);
    chk("clear_q_man", {5'b0, q_man}, 32'd0);
    wait_done(0, edges, busy_ok);
    chk("clear_run_q_man", {5'b0, q_man}, {5'b0, 27'h2AAAAAA});

    chk("residual_bound", inv_viol, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
